// File: rtl/bnd_ser_tx.sv
// Serial transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// Each bit is held for DIV clocks. The line output comes from a flop, and ready/busy are decoded from the state register.
module bnd_ser_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             x_q, x_d;

    logic             div_last_s;
    logic [DW-1:0]    div_inc_s;
    logic [WIDTH-1:0] sh_shift_s;

    assign div_last_s = (div_q == DIV_LAST);
    assign div_inc_s  = div_last_s ? {DW{1'b0}} : div_q + DW'(1);
    assign sh_shift_s = sh_q >> 1;

    // Next-state logic. x_d always holds the level for the next state, so the line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    sh_d    = din;
                    bit_d   = {BW{1'b0}};
                    div_d   = {DW{1'b0}};
                    state_d = START;
                    x_d     = 1'b0;
                end else begin
                    x_d     = 1'b1;
                end
            end
            START: begin
                div_d = div_inc_s;
                if (div_last_s) begin
                    state_d = DATA;
                    x_d     = sh_q[0];
                end else begin
                    x_d     = 1'b0;
                end
            end
            DATA: begin
                div_d = div_inc_s;
                if (div_last_s) begin
                    sh_d  = sh_shift_s;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        x_d     = 1'b1;
                    end else begin
                        x_d     = sh_shift_s[0];
                    end
                end else begin
                    x_d = sh_q[0];
                end
            end
            STOP: begin
                div_d = div_inc_s;
                x_d   = 1'b1;
                if (div_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = {DW{1'b0}};
                bit_d   = {BW{1'b0}};
                sh_d    = {WIDTH{1'b0}};
                x_d     = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and line flop. Reset forces an idle-high line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= {DW{1'b0}};
            bit_q   <= {BW{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            x_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            x_q     <= x_d;
        end
    end

    assign x     = x_q;
    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bnd_ser_tx.sv
// Directed bench for bnd_ser_tx. One instance uses WIDTH=8, DIV=4 and the other uses WIDTH=4, DIV=1.
module tb_bnd_ser_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       valid;
    logic       ready, x, busy;
    logic [3:0] din1;
    logic       valid1;
    logic       ready1, x1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bnd_ser_tx #(.WIDTH(8), .DIV(4)) dut (
        .clk(clk), .rst(rst), .din(din), .valid(valid),
        .ready(ready), .x(x), .busy(busy)
    );

    bnd_ser_tx #(.WIDTH(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .valid(valid1),
        .ready(ready1), .x(x1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle c of a frame (DIV=4, WIDTH=8)
    function automatic logic fbit(input logic [7:0] d, input int c);
        int k;
        k = c / 4;
        if (k == 0)      return 1'b0;
        else if (k == 9) return 1'b1;
        else             return d[k-1];
    endfunction

    // Called one sample after the acceptance edge. Checks 40 frame cycles and then the idle cycle that follows.
    // If pulse_at < 40, valid is pulsed with din=3C at that cycle.
    task automatic check_frame(input string tag, input logic [7:0] d, input int pulse_at);
        for (int i = 0; i < 40; i++) begin
            if (i == pulse_at) begin
                valid = 1'b1;
                din   = 8'h3C;
            end else if (i == pulse_at + 1) begin
                valid = 1'b0;
            end
            chk({tag, "_x"}, {31'd0, x}, {31'd0, fbit(d, i)});
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
            tick();
        end
        chk({tag, "_idle_x"}, {31'd0, x}, 32'd1);
        chk({tag, "_idle_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [5:0] exp1;
        rst    = 1'b1;
        valid  = 1'b0;
        din    = 8'h00;
        valid1 = 1'b0;
        din1   = 4'h0;
        #2;
        chk("rst_x", {31'd0, x}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_x1", {31'd0, x1}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frame with A5; the line sequence is 0,1,0,1,0,0,1,0,1,1
        valid = 1'b1;
        din   = 8'hA5;
        tick();
        valid = 1'b0;
        din   = 8'h00;
        check_frame("a5", 8'hA5, 100);
        tick();
        tick();

        // Back-to-back frames with valid held high. din changes right after the first acceptance.
        valid = 1'b1;
        din   = 8'h00;
        tick();
        din = 8'hFF;
        check_frame("b2b0", 8'h00, 100);
        tick();
        valid = 1'b0;
        check_frame("b2bff", 8'hFF, 100);
        tick();

        // A request made during a frame is ignored and not queued
        valid = 1'b1;
        din   = 8'h5A;
        tick();
        valid = 1'b0;
        check_frame("ign", 8'h5A, 14);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ign_noframe_busy", {31'd0, busy}, 32'd0);
            chk("ign_noframe_x", {31'd0, x}, 32'd1);
        end

        // Reset during data bit 3; valid is held high while reset is asserted
        valid = 1'b1;
        din   = 8'h96;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            chk("pre_rst_x", {31'd0, x}, {31'd0, fbit(8'h96, i)});
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_x", {31'd0, x}, 32'd1);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        valid = 1'b1;
        din   = 8'h11;
        tick();
        chk("rst_valid_ignored", {31'd0, busy}, 32'd0);
        valid = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_x", {31'd0, x}, 32'd1);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        valid = 1'b1;
        din   = 8'h5A;
        tick();
        valid = 1'b0;
        check_frame("after_rst", 8'h5A, 100);

        // DIV=1, WIDTH=4, din=1001; the line sequence is 0,1,0,0,1,1
        exp1   = 6'b110010;
        valid1 = 1'b1;
        din1   = 4'b1001;
        tick();
        valid1 = 1'b0;
        din1   = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            chk("div1_x", {31'd0, x1}, {31'd0, exp1[i]});
            chk("div1_ready", {31'd0, ready1}, 32'd0);
            tick();
        end
        chk("div1_ready_back", {31'd0, ready1}, 32'd1);
        chk("div1_busy_done", {31'd0, busy1}, 32'd0);
        chk("div1_idle_x", {31'd0, x1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnd_ser_tx.md
BND_SER_TX -- requirements
Module: bnd_ser_tx

Interface
REQ-001 Parameter WIDTH, default 8, is the number of data bits per frame (legal range 1..32).
REQ-002 Parameter DIV, default 4, is the number of clk cycles per serial bit (legal range 1..1024).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-006 valid  input  1  din holds a word to send.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  serial line, registered; idle level 1.
REQ-009 busy  output  1  a frame is in progress (any state other than IDLE).

Function
REQ-010 Frame format SHALL be: start bit (0), WIDTH data bits LSB first, stop bit (1).
REQ-011 Each bit SHALL be held on x for exactly DIV consecutive cycles.
REQ-012 A frame SHALL therefore occupy (WIDTH+2)*DIV cycles.
REQ-013 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-014 IDLE behaviour:
- x=1, ready=1, busy=0.
- On valid&&ready, din SHALL be latched into the shift register, the bit counter cleared, the divide counter cleared, and the state SHALL move to START.
REQ-015 START: x=0 for DIV cycles, then the state SHALL move to DATA.
REQ-016 DATA:
- x = shift register bit 0.
- After every DIV cycles, shift right by 1 and increment the bit counter.
- After the WIDTH-th bit completes, the state SHALL move to STOP.
REQ-017 STOP: x=1 for DIV cycles, then the state SHALL return to IDLE.
REQ-018 Acceptance latency: x SHALL go low on the cycle immediately following the acceptance edge.
REQ-019 ready SHALL be asserted only in IDLE; valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 Back-to-back frames SHALL be separated by exactly one idle cycle (x=1) when valid is held high continuously.
REQ-021 din changes after acceptance SHALL NOT affect the frame in progress.
REQ-022 The divide counter SHALL be ceil(log2(DIV)) bits wide (minimum 1) and SHALL wrap from DIV-1 to 0.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide (minimum 1).
REQ-024 When DIV=1, each bit SHALL last one cycle with no skipped or duplicated bits.
REQ-025 x, ready and busy SHALL be driven directly from flops or from the state register, with no combinational path from valid or din.

Reset
REQ-026 Asserting rst SHALL immediately force:
- state = IDLE, x=1, ready=1, busy=0;
- both counters and the shift register = 0.
REQ-027 Asserting rst mid-frame SHALL abort the frame with no further bits emitted.
REQ-028 After rst deasserts, the first accepted word SHALL start a complete new frame.
REQ-029 valid asserted while rst is high SHALL NOT be accepted.

Verification
REQ-030 Single frame: WIDTH=8, DIV=4, din=8'hA5 with one valid pulse -> x sequence over 40 cycles is 0,1,0,1,0,0,1,0,1,1 (each bit held 4 cycles); busy high 40 cycles.
REQ-031 Back-to-back: valid held high with din=8'h00 then 8'hFF -> second start bit begins exactly 41 cycles after the first; one idle-high cycle between frames.
REQ-032 Ignored request: pulse valid with din=8'h3C mid-frame -> no second frame; the current frame is unchanged.
REQ-033 Reset mid-frame: assert rst during DATA bit 3 -> x=1, ready=1 on the same edge; the next request transmits a full 40-cycle frame.
REQ-034 DIV=1, WIDTH=4, din=4'b1001 -> x = 0,1,0,0,1,1 over 6 cycles; ready returns on cycle 7.
REQ-035 Data stability: change din on the cycle after acceptance -> the transmitted bits match the originally accepted value.
